// File: rtl/n_arbiter.sv
// n_arbiter: registered N-way request arbiter (N = 2**W) built around a
// priority-encode core.
//
// Two runtime modes are selected at arbitration time:
//   mode = 0 : fixed priority, the lowest set request index wins.
//   mode = 1 : round-robin, the search starts at ptr (one past the last owner).
// A grant is held while its request stays high. After HOLD_MAX consecutive
// cycles the owner is forced off if anyone else is waiting. HOLD_MAX = 0
// disables the forced release.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        request vector, bit i = requester i
//   mode       0 = fixed priority, 1 = round-robin
//   gnt        one-hot grant (registered)
//   gnt_idx    binary index of the owner (registered; holds the last owner in IDLE)
//   gnt_valid  high while a grant is active (registered)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; any nonzero req is arbitrated at the next edge
// OWN   | gnt_idx owns the resource; release on drop or hold limit
module n_arbiter #(
    parameter int W        = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [(2**W)-1:0]   req,
    input  logic                mode,
    output logic [(2**W)-1:0]   gnt,
    output logic [W-1:0]        gnt_idx,
    output logic                gnt_valid
);

    localparam int N  = 2 ** W;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state;
    logic [W-1:0]    ptr;
    logic [HW-1:0]   hold_cnt;

    logic [W-1:0]    fp_idx;
    logic [W-1:0]    rr_idx;
    logic [W-1:0]    rr_cand;
    logic            rr_found;
    logic [W-1:0]    win_idx;
    logic [N-1:0]    others;
    logic            hold_expired;
    logic            release_now;

    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        fp_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                fp_idx = W'(i);
            end
        end
    end

    // Round-robin: first set bit at ptr, ptr+1, ... ; the W-bit add wraps mod N.
    always_comb begin
        rr_idx   = ptr;
        rr_cand  = ptr;
        rr_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            rr_cand = ptr + W'(i);
            if (!rr_found && req[rr_cand]) begin
                rr_idx   = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    assign win_idx = mode ? rr_idx : fp_idx;

    // In OWN, gnt is exactly the owner's one-hot bit, so this masks the owner.
    assign others       = req & ~gnt;
    assign hold_expired = (HOLD_MAX != 0) && (hold_cnt == HMAX) && (|others);
    assign release_now  = !req[gnt_idx] || hold_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HW'(1);
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        // gnt_idx keeps the old owner so it stays readable in IDLE.
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + W'(1);
                        state     <= IDLE;
                    end else if ((HOLD_MAX != 0) && (hold_cnt != HMAX)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_arbiter.sv
module tb_n_arbiter;

    localparam int W    = 3;
    localparam int N    = 8;
    localparam int HOLD = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   gnt;
    logic [W-1:0]   gnt_idx;
    logic           gnt_valid;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: owner, ptr and hold count as plain integers.
    int m_valid = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_hold  = 0;

    n_arbiter #(.W(W), .HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input logic md, input int p);
        int c;
        for (int k = 0; k < N; k++) begin
            c = md ? (p + k) % N : k;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    // Model step at each edge, then compare the DUT 1 time unit later.
    always @(posedge clk) begin
        logic [N-1:0] oth;
        if (reset) begin
            m_valid = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        end else if (m_valid == 0) begin
            if (req != 0) begin
                m_owner = pick(req, mode, m_ptr);
                m_valid = 1;
                m_hold  = 1;
            end
        end else begin
            oth = req & ~(N'(1) << m_owner);
            if (!req[m_owner] || (HOLD > 0 && m_hold == HOLD && oth != 0)) begin
                m_valid = 0;
                m_ptr   = (m_owner + 1) % N;
            end else if (m_hold < HOLD) begin
                m_hold = m_hold + 1;
            end
        end
        #1;
        chk("model_gnt_valid", 32'(gnt_valid), 32'(m_valid));
        chk("model_gnt_idx", 32'(gnt_idx), 32'(m_owner));
        chk("model_gnt", 32'(gnt), (m_valid != 0) ? (32'd1 << m_owner) : 32'd0);
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        mode  = 1'b0;

        // 1. reset with all requests high
        @(negedge clk);
        req = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_valid", 32'(gnt_valid), 32'h0);
            chk("rst_idx", 32'(gnt_idx), 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("first_grant_valid", 32'(gnt_valid), 32'h1);
        chk("first_grant_idx", 32'(gnt_idx), 32'h0);

        reset = 1'b1; req = '0;
        @(negedge clk);
        reset = 1'b0;

        // 2. fixed priority
        mode = 1'b0; req = 8'b1010_0100;
        @(negedge clk);
        chk("fp_idx2", 32'(gnt_idx), 32'h2);
        chk("fp_gnt04", 32'(gnt), 32'h04);
        req = 8'b1010_0000;
        @(negedge clk);
        chk("fp_release", 32'(gnt_valid), 32'h0);
        @(negedge clk);
        chk("fp_idx5", 32'(gnt_idx), 32'h5);
        chk("fp_gnt20", 32'(gnt), 32'h20);

        // 4. wrap-around: owner 5 releases, ptr becomes 6
        req = '0;
        @(negedge clk);
        chk("wrap_released", 32'(gnt_valid), 32'h0);
        mode = 1'b1; req = 8'b0000_0011;
        @(negedge clk);
        chk("wrap_idx0", 32'(gnt_idx), 32'h0);
        req = '0;
        repeat (2) @(negedge clk);

        // 3. round-robin forced rotation with all requests held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mode = 1'b1; req = 8'hFF;
        for (int o = 0; o <= 8; o++) begin
            repeat (4) begin
                @(negedge clk);
                chk("rr_valid", 32'(gnt_valid), 32'h1);
                chk("rr_owner", 32'(gnt_idx), 32'(o % 8));
            end
            @(negedge clk);
            chk("rr_gap", 32'(gnt_valid), 32'h0);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // 5. lone requester is never forced off
        req = 8'h10;
        repeat (20) begin
            @(negedge clk);
            chk("lone_valid", 32'(gnt_valid), 32'h1);
            chk("lone_idx", 32'(gnt_idx), 32'h4);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // 6. mode change mid-grant, reset mid-grant
        mode = 1'b0; req = 8'h08;
        @(negedge clk);
        chk("own3_idx", 32'(gnt_idx), 32'h3);
        mode = 1'b1;
        @(negedge clk);
        chk("mode_toggle_valid", 32'(gnt_valid), 32'h1);
        chk("mode_toggle_idx", 32'(gnt_idx), 32'h3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_valid", 32'(gnt_valid), 32'h0);
        chk("midrst_idx", 32'(gnt_idx), 32'h0);
        reset = 1'b0; mode = 1'b1; req = 8'h88;
        @(negedge clk);
        chk("post_rst_idx3", 32'(gnt_idx), 32'h3);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = N'($urandom);
                    1: req = N'($urandom & $urandom);
                    2: req = N'(1) << $urandom_range(0, N - 1);
                    default: req = '0;
                endcase
            end else if ($urandom_range(0, 9) == 0 && gnt_valid) begin
                req[gnt_idx] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) mode = ~mode;
        end
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
